// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier, start/busy/done handshake
//   clk, rst_n           clock, asynchronous active-low reset
//   start                request; operands captured on the accepted edge
//   multiplicand (M)     signed WIDTH-bit operand
//   multiplier (Q)       signed WIDTH-bit operand
//   busy                 high while in CALC
//   done                 one-cycle pulse when product is updated
//   product              registered signed 2*WIDTH-bit M*Q, held until next done
module booth_mult_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t               state_q, state_d;
  logic                 pend_q, pend_d;
  logic [WIDTH-1:0]     m_q, m_d, q_q, q_d;
  logic [WIDTH:0]       a_q, a_d;
  logic                 q1_q, q1_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH:0]       m_ext, alu_a, alu_b, acc, a_n;
  logic                 alu_cin, sub, add, accept, q1_n;
  logic [WIDTH-1:0]     q_n;
  // M is sign-extended one bit so -2^(WIDTH-1) survives subtraction
  assign m_ext   = {m_q[WIDTH-1], m_q};
  assign sub     = q_q[0] & ~q1_q;
  assign add     = ~q_q[0] & q1_q;
  // Operands as presented to the add/subtract ALU: subtract is A + ~M + 1
  assign alu_a   = a_q;
  assign alu_b   = sub ? ~m_ext : m_ext;
  assign alu_cin = sub;
  assign acc     = (sub | add) ? alu_a + alu_b + {{WIDTH{1'b0}}, alu_cin} : a_q;
  // Arithmetic shift right of {A,Q,Q_1}
  assign {a_n, q_n, q1_n} = {acc[WIDTH], acc, q_q};
  // Start is taken in a settled IDLE or in DONE (back-to-back); ignored in CALC
  assign accept  = start && ((state_q == IDLE && !pend_q) || state_q == DONE);
  always_comb begin
    state_d = state_q;
    pend_d  = 1'b0;
    m_d     = m_q;
    q_d     = q_q;
    a_d     = a_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: state_d = pend_q ? CALC : IDLE;
      CALC: begin
        a_d     = a_n;
        q_d     = q_n;
        q1_d    = q1_n;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == 1) ? DONE : CALC;
        prod_d  = (cnt_q == 1) ? {a_n[WIDTH-1:0], q_n} : prod_q;
      end
      default: state_d = IDLE;
    endcase
    // Operands are captured on the accepted edge; CALC begins one edge later
    if (accept) begin
      state_d = IDLE;
      pend_d  = 1'b1;
      m_d     = multiplicand;
      q_d     = multiplier;
      a_d     = '0;
      q1_d    = 1'b0;
      cnt_d   = CNT_W'(WIDTH);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      m_q     <= '0;
      q_q     <= '0;
      a_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      m_q     <= m_d;
      q_q     <= q_d;
      a_q     <= a_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end
  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = prod_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed self-checking bench for booth_mult_seq
module tb_booth_mult_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  mc = '0, mp = '0;
  logic        busy, done;
  logic [15:0] product;
  int vec = 0, err = 0;

  booth_mult_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .multiplicand(mc),
    .multiplier(mp), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  // Pulse start with (m,q), count edges to done; optionally keep start high
  // and scramble operands while the operation is in flight.
  task automatic run_op(input logic [7:0] m, input logic [7:0] q, input bit noisy,
                        output logic [15:0] p, output int lat, output int bcnt,
                        output bit ovl, output bit dbl);
    lat = -1; bcnt = 0; ovl = 0; dbl = 0; p = 'x;
    @(negedge clk);
    start = 1'b1; mc = m; mp = q;
    @(posedge clk); #1;
    start = noisy; mc = 8'($urandom); mp = 8'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (busy && done) ovl = 1;
      if (done) begin
        lat = k; p = product; start = 1'b0;
        break;
      end
      if (noisy) begin mc = 8'($urandom); mp = 8'($urandom); end
    end
    @(posedge clk); #1;
    dbl = done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy got %b want 0", busy); end
    vec++; if (done !== 1'b0) begin err++; $display("FAIL reset_done got %b want 0", done); end
    vec++; if (product !== 16'h0000) begin err++; $display("FAIL reset_product got %h want 0000", product); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [15:0] p; int lat, bc; bit ovl, dbl;
    run_op(8'd3, 8'd5, 0, p, lat, bc, ovl, dbl);
    vec++; if (p !== 16'h000F) begin err++; $display("FAIL basic_product got %h want 000f", p); end
    vec++; if (lat !== 9) begin err++; $display("FAIL basic_latency got %0d want 9", lat); end
    vec++; if (bc !== 8) begin err++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
    vec++; if (ovl !== 0) begin err++; $display("FAIL basic_busy_done_overlap got %b want 0", ovl); end
    vec++; if (dbl !== 0) begin err++; $display("FAIL basic_done_width got %b want 0", dbl); end
    vec++; if (product !== 16'h000F) begin err++; $display("FAIL basic_hold got %h want 000f", product); end
  endtask

  task automatic test_signs;
    logic [7:0]  tm [6] = '{8'hFD, 8'h05, 8'h80, 8'h80, 8'h7F, 8'h00};
    logic [7:0]  tq [6] = '{8'h05, 8'hFD, 8'h80, 8'h7F, 8'h7F, 8'h9A};
    logic [15:0] te [6] = '{16'hFFF1, 16'hFFF1, 16'h4000, 16'hC080, 16'h3F01, 16'h0000};
    logic [15:0] p; int lat, bc; bit ovl, dbl;
    for (int i = 0; i < 6; i++) begin
      run_op(tm[i], tq[i], 0, p, lat, bc, ovl, dbl);
      vec++; if (p !== te[i]) begin err++; $display("FAIL signs_product[%0d] got %h want %h", i, p, te[i]); end
      vec++; if (lat !== 9) begin err++; $display("FAIL signs_latency[%0d] got %0d want 9", i, lat); end
    end
  endtask

  task automatic test_busy_noise;
    logic [15:0] p; int lat, bc; bit ovl, dbl;
    run_op(8'd7, 8'hFA, 1, p, lat, bc, ovl, dbl);
    vec++; if (p !== 16'hFFD6) begin err++; $display("FAIL noise_product got %h want ffd6", p); end
    vec++; if (lat !== 9) begin err++; $display("FAIL noise_latency got %0d want 9", lat); end
    vec++; if (bc !== 8) begin err++; $display("FAIL noise_busy_cycles got %0d want 8", bc); end
  endtask

  task automatic test_back_to_back;
    int lat1 = -1, lat2 = -1;
    @(negedge clk);
    start = 1'b1; mc = 8'd12; mp = 8'd12;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin lat1 = k; break; end
    end
    vec++; if (product !== 16'h0090) begin err++; $display("FAIL b2b_first got %h want 0090", product); end
    vec++; if (lat1 !== 9) begin err++; $display("FAIL b2b_first_latency got %0d want 9", lat1); end
    start = 1'b1; mc = 8'hFF; mp = 8'hFF;
    @(posedge clk); #1; start = 1'b0; mc = 8'h55; mp = 8'h33;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin lat2 = k; break; end
    end
    vec++; if (lat2 !== 9) begin err++; $display("FAIL b2b_second_latency got %0d want 9", lat2); end
    vec++; if (product !== 16'h0001) begin err++; $display("FAIL b2b_second got %h want 0001", product); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_mid_reset;
    logic [15:0] p; int lat, bc; bit ovl, dbl, seen = 0;
    @(negedge clk);
    start = 1'b1; mc = 8'd9; mp = 8'd9;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    vec++; if (busy !== 1'b1) begin err++; $display("FAIL midrst_pre_busy got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL midrst_busy got %b want 0", busy); end
    vec++; if (product !== 16'h0000) begin err++; $display("FAIL midrst_product got %h want 0000", product); end
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    vec++; if (seen !== 0) begin err++; $display("FAIL midrst_no_resume got %b want 0", seen); end
    run_op(8'd10, 8'd20, 0, p, lat, bc, ovl, dbl);
    vec++; if (p !== 16'h00C8) begin err++; $display("FAIL midrst_after got %h want 00c8", p); end
    vec++; if (lat !== 9) begin err++; $display("FAIL midrst_after_latency got %0d want 9", lat); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signs;
    test_busy_noise;
    test_back_to_back;
    test_mid_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
